seg_anim_seq: RTL and testbench

- Parametrised successor to the 4-digit heartbeat animator.
- Drives NUM_DIGITS active-low 7-segment+DP digit codes from a runtime-writable pattern table.
- Stages advance on a prescaled tick after a programmable dwell.
- Four sequencing modes (loop, loop-no-blank, ping-pong, one-shot), with run/restart control and status outputs. Sits between the board clock domain and the display mux/driver.

---
 rtl/seg_anim_seq_pkg.sv | 20 ++
 rtl/seg_anim_seq_if.sv | 32 +++
 rtl/seg_anim_seq_tick.sv | 30 +++
 rtl/seg_anim_seq.sv | 136 +++++++++++++
 tb/tb_seg_anim_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seg_anim_seq_pkg.sv
// Shared constants, types and helpers for the segment animation sequencer.
package seg_anim_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_LOOP_NB  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;
  localparam logic [1:0] MODE_ONESHOT  = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic {DirUp, DirDown} dir_e;

  function automatic int unsigned clog2(input int unsigned val);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(val)) res++;
    return res;
  endfunction

endpackage

// File: rtl/seg_anim_seq_if.sv
// Control, table-write and status bundle between a host and seg_anim_seq.
interface seg_anim_seq_if #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned DWELL_W    = 18
);
  localparam int unsigned STAGE_W = seg_anim_pkg::clog2(NUM_STAGES + 1);
  localparam int unsigned DIGIT_W = (NUM_DIGITS > 1) ? seg_anim_pkg::clog2(NUM_DIGITS) : 1;

  logic                    run;
  logic                    restart;
  logic [1:0]              mode;
  logic [DWELL_W-1:0]      dwell_len;
  logic                    wr_en;
  logic [STAGE_W-1:0]      wr_stage;
  logic [DIGIT_W-1:0]      wr_digit;
  logic [7:0]              wr_data;
  logic [NUM_DIGITS*8-1:0] dig;
  logic [STAGE_W-1:0]      stage;
  logic                    busy;
  logic                    done;

  modport master (
    output run, restart, mode, dwell_len, wr_en, wr_stage, wr_digit, wr_data,
    input  dig, stage, busy, done
  );

  modport slave (
    input  run, restart, mode, dwell_len, wr_en, wr_stage, wr_digit, wr_data,
    output dig, stage, busy, done
  );
endinterface

// File: rtl/seg_anim_seq_tick.sv
// Free-running prescaler: one-cycle tick every PRESCALE_MAX+1 enabled clocks.
module seg_anim_tick
  import seg_anim_pkg::*;
#(
  parameter int unsigned PRESCALE_MAX = 1389000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);
  localparam int unsigned CNT_W = (clog2(PRESCALE_MAX + 1) < 1) ? 1 : clog2(PRESCALE_MAX + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == CNT_W'(PRESCALE_MAX));
  assign o_tick = i_en & w_term;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/seg_anim_seq.sv
// Pattern-table 7-segment animator: stage sequencing, writable table, registered digits.
module seg_anim_seq
  import seg_anim_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned PRESCALE_MAX = 1389000,
  parameter int unsigned DWELL_W      = 18
) (
  input  logic           i_clk,
  input  logic           i_rst,
  seg_anim_seq_if.slave  bus
);
  localparam int unsigned STAGE_W = clog2(NUM_STAGES + 1);
  localparam int unsigned DIGIT_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
  localparam logic [STAGE_W-1:0] LAST = STAGE_W'(NUM_STAGES);

  logic [DWELL_W-1:0]      r_dwell;
  logic [STAGE_W-1:0]      r_stage;
  dir_e                    r_dir;
  logic                    r_halted;
  logic                    r_done;
  logic [NUM_DIGITS*8-1:0] r_dig;
  logic [7:0]              r_table [NUM_STAGES][NUM_DIGITS];

  logic                    w_tick;
  logic [STAGE_W-1:0]      w_nxt_stage;
  dir_e                    w_nxt_dir;
  logic [NUM_DIGITS*8-1:0] w_row;

  seg_anim_tick #(
    .PRESCALE_MAX(PRESCALE_MAX)
  ) u_tick (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (bus.run & ~r_halted),
    .i_clr (bus.restart),
    .o_tick(w_tick)
  );

  always_comb begin
    w_nxt_stage = r_stage;
    w_nxt_dir   = r_dir;
    case (bus.mode)
      MODE_LOOP, MODE_ONESHOT: w_nxt_stage = (r_stage == LAST) ? '0 : r_stage + 1'b1;
      MODE_LOOP_NB:            w_nxt_stage = (r_stage == LAST) ? STAGE_W'(1) : r_stage + 1'b1;
      MODE_PINGPONG: begin
        if (r_stage == '0 || NUM_STAGES == 1) begin
          w_nxt_stage = STAGE_W'(1);
          w_nxt_dir   = DirUp;
        end else if (r_dir == DirUp) begin
          // >= / <= guard against a stage left out of range by a mode switch
          if (r_stage >= LAST) begin
            w_nxt_stage = LAST - 1'b1;
            w_nxt_dir   = DirDown;
          end else begin
            w_nxt_stage = r_stage + 1'b1;
          end
        end else if (r_stage <= STAGE_W'(1)) begin
          w_nxt_stage = STAGE_W'(2);
          w_nxt_dir   = DirUp;
        end else begin
          w_nxt_stage = r_stage - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dwell  <= '0;
      r_stage  <= '0;
      r_dir    <= DirUp;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else if (bus.restart) begin
      r_dwell  <= '0;
      r_stage  <= '0;
      r_dir    <= DirUp;
      r_halted <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_halted && bus.mode != MODE_ONESHOT) r_halted <= 1'b0;
      if (w_tick) begin
        if (r_dwell >= bus.dwell_len) begin
          r_dwell <= '0;
          r_stage <= w_nxt_stage;
          r_dir   <= w_nxt_dir;
          if (bus.mode == MODE_ONESHOT && r_stage == LAST) begin
            r_halted <= 1'b1;
            r_done   <= 1'b1;
          end
        end else begin
          r_dwell <= r_dwell + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < NUM_STAGES; s++)
        for (int d = 0; d < NUM_DIGITS; d++) r_table[s][d] <= SEG_BLANK;
    end else if (bus.wr_en) begin
      for (int s = 0; s < NUM_STAGES; s++)
        for (int d = 0; d < NUM_DIGITS; d++)
          if (bus.wr_stage == STAGE_W'(s + 1) && bus.wr_digit == DIGIT_W'(d))
            r_table[s][d] <= bus.wr_data;
    end
  end

  // Stage 0 has no table entry and always reads as blank.
  always_comb begin
    w_row = {NUM_DIGITS{SEG_BLANK}};
    for (int s = 0; s < NUM_STAGES; s++)
      if (r_stage == STAGE_W'(s + 1))
        for (int d = 0; d < NUM_DIGITS; d++) w_row[8*d +: 8] = r_table[s][d];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dig <= {NUM_DIGITS{SEG_BLANK}};
    end else if (bus.restart) begin
      r_dig <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      r_dig <= w_row;
    end
  end

  assign bus.dig   = r_dig;
  assign bus.stage = r_stage;
  assign bus.busy  = bus.run & ~r_halted;
  assign bus.done  = r_done;
endmodule

// File: tb/tb_seg_anim_seq.sv
// Directed bench for seg_anim_seq: prescale 3, dwell_len 1 gives 8 clocks per stage.
module tb_seg_anim_seq;
  import seg_anim_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  seg_anim_seq_if #(.NUM_DIGITS(4), .NUM_STAGES(4), .DWELL_W(18)) bus ();

  seg_anim_seq #(
    .NUM_DIGITS  (4),
    .NUM_STAGES  (4),
    .PRESCALE_MAX(3),
    .DWELL_W     (18)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Table pattern written below: digit d of stage s holds {s, d}.
  function automatic logic [31:0] row(input int s);
    logic [31:0] r;
    if (s == 0) return 32'hFFFF_FFFF;
    for (int d = 0; d < 4; d++) r[8*d +: 8] = 8'((s << 4) | d);
    return r;
  endfunction

  // Entered just after the edge that started counting from a clean prescaler.
  task automatic run_seq(input int seq[$]);
    step(7);
    check("stage_hold", 64'(bus.stage), 64'(seq[0]));
    for (int i = 1; i < seq.size(); i++) begin
      step(1);
      check("stage_adv", 64'(bus.stage), 64'(seq[i]));
      check("busy_run", 64'(bus.busy), 64'd1);
      step(1);
      check("dig_row", 64'(bus.dig), 64'(row(seq[i])));
      step(6);
      check("stage_hold", 64'(bus.stage), 64'(seq[i]));
    end
  endtask

  initial begin
    bus.run = 1'b0; bus.restart = 1'b0; bus.mode = MODE_LOOP; bus.dwell_len = 18'd1;
    bus.wr_en = 1'b0; bus.wr_stage = '0; bus.wr_digit = '0; bus.wr_data = '0;
    step(2);
    check("rst_dig", 64'(bus.dig), 64'hFFFF_FFFF);
    check("rst_stage", 64'(bus.stage), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b0;

    for (int s = 1; s <= 4; s++) begin
      for (int d = 0; d < 4; d++) begin
        bus.wr_en = 1'b1; bus.wr_stage = 3'(s); bus.wr_digit = 2'(d);
        bus.wr_data = 8'((s << 4) | d);
        step(1);
      end
    end
    // Out-of-range stages must be dropped.
    bus.wr_stage = 3'd0; bus.wr_digit = 2'd0; bus.wr_data = 8'h00; step(1);
    bus.wr_stage = 3'd5; bus.wr_digit = 2'd2; bus.wr_data = 8'h00; step(1);
    bus.wr_en = 1'b0;

    bus.run = 1'b1;
    run_seq('{0, 1, 2, 3, 4, 0});

    // The restart edge coincides with an advance; restart must win.
    bus.mode = MODE_PINGPONG; bus.restart = 1'b1; step(1); bus.restart = 1'b0;
    check("restart_wins", 64'(bus.stage), 64'd0);
    run_seq('{0, 1, 2, 3, 4, 3, 2, 1, 2});

    bus.mode = MODE_ONESHOT; bus.restart = 1'b1; step(1); bus.restart = 1'b0;
    check("restart_stage", 64'(bus.stage), 64'd0);
    check("restart_dig", 64'(bus.dig), 64'hFFFF_FFFF);
    run_seq('{0, 1, 2, 3, 4});
    step(1);
    check("os_stage", 64'(bus.stage), 64'd0);
    check("os_done", 64'(bus.done), 64'd1);
    check("os_busy", 64'(bus.busy), 64'd0);
    step(1);
    check("os_done_pulse", 64'(bus.done), 64'd0);
    check("os_dig", 64'(bus.dig), 64'hFFFF_FFFF);
    step(100);
    check("os_hold_stage", 64'(bus.stage), 64'd0);
    check("os_hold_busy", 64'(bus.busy), 64'd0);
    check("os_hold_done", 64'(bus.done), 64'd0);

    bus.restart = 1'b1; step(1); bus.restart = 1'b0;
    check("os_restart_busy", 64'(bus.busy), 64'd1);
    run_seq('{0, 1});
    step(1);
    check("pause_enter", 64'(bus.stage), 64'd2);
    step(3);
    bus.run = 1'b0;
    step(20);
    check("pause_stage", 64'(bus.stage), 64'd2);
    check("pause_busy", 64'(bus.busy), 64'd0);
    bus.run = 1'b1;
    step(4);
    check("pause_remain", 64'(bus.stage), 64'd2);
    step(1);
    check("pause_exit", 64'(bus.stage), 64'd3);

    bus.wr_en = 1'b1; bus.wr_stage = 3'd3; bus.wr_digit = 2'd1; bus.wr_data = 8'hA5;
    step(1);
    bus.wr_en = 1'b0;
    check("wr_old_row", 64'(bus.dig), 64'h3332_3130);
    step(1);
    check("wr_new_row", 64'(bus.dig), 64'h3332_A530);

    bus.mode = MODE_LOOP; bus.dwell_len = 18'd7;
    bus.restart = 1'b1; step(1); bus.restart = 1'b0;
    step(12);
    bus.dwell_len = 18'd0;
    step(3);
    check("dwell_before", 64'(bus.stage), 64'd0);
    step(1);
    check("dwell_shrink", 64'(bus.stage), 64'd1);
    step(4);
    check("dwell_zero", 64'(bus.stage), 64'd2);

    #3 rst = 1'b1;
    #1;
    check("async_dig", 64'(bus.dig), 64'hFFFF_FFFF);
    check("async_stage", 64'(bus.stage), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; bus.dwell_len = 18'd1;
    step(8);
    check("post_rst_stage", 64'(bus.stage), 64'd1);
    step(1);
    check("post_rst_table", 64'(bus.dig), 64'hFFFF_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
